// File: rtl/uart_pkg.sv
// Shared definitions for the multi-requester UART transmitter.
// This package holds the FSM state encoding and the frame format constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_STOP_BITS  = 1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
// The search starts at i_ptr and wraps modulo NUM_REQ. The grant is one-hot, or zero when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx   = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// This module time-shares one 8N1 UART transmit line between NUM_REQ byte sources, using round-robin arbitration.
// A byte is captured on its accept edge and is then sent from this module's own shift register.
//   state | meaning
//   IDLE  | line high; accept one byte from the arbiter winner
//   START | start bit (low) for one bit time
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (high) for one bit time
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(UART_STOP_BITS - 1);

  uart_state_e               r_state;
  uart_state_e               w_next_state;
  logic [CNT_W-1:0]          r_baud;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic [IDX_W-1:0]          r_grant_id;
  logic [IDX_W-1:0]          r_ptr;
  logic [NUM_REQ-1:0]        w_arb_grant;
  logic [IDX_W-1:0]          w_arb_idx;
  logic                      w_bit_done;
  logic                      w_accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  assign w_bit_done = (r_baud == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // The grant is gated with rst so that no byte is ever taken on a reset edge.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready    = w_arb_grant;
          w_accept     = 1'b1;
          w_next_state = START;
        end
      end
      START: if (w_bit_done) w_next_state = DATA;
      DATA:  if (w_bit_done && r_bit_idx == LAST_DATA) w_next_state = STOP;
      STOP:  if (w_bit_done && r_bit_idx == LAST_STOP) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= UART_IDLE_LEVEL;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else begin
      if (r_state == IDLE || w_bit_done) r_baud <= '0;
      else                               r_baud <= r_baud + 1'b1;
      // The tx register is loaded one edge ahead, so that it changes on the same edge as the state.
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= req_data[8*w_arb_idx +: 8];
            r_tx       <= 1'b0;
            r_grant_id <= w_arb_idx;
            r_ptr      <= (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
            r_bit_idx  <= '0;
          end
        end
        START: begin
          if (w_bit_done) r_tx <= r_shift[0];
        end
        DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_DATA) begin
              r_tx      <= UART_IDLE_LEVEL;
              r_bit_idx <= '0;
            end else begin
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_bit_done) r_bit_idx <= (r_bit_idx == LAST_STOP) ? '0 : r_bit_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched with NUM_REQ=4 and CLKS_PER_BIT=4. It uses directed scenarios plus a randomized phase.
// A frame-level reference model checks tx, busy, grant_id and req_ready in every cycle.
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;
  int busy_cnt = 0;

  // The reference model tracks whether a frame is active and the position within that frame.
  bit         m_busy;
  int         m_t;
  int         m_gid;
  int         m_ptr;
  logic [7:0] m_byte;

  int   g_idx[$];
  int   g_cyc[$];
  logic tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle_no);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_t / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode(input int acc);
    logic [7:0] d;
    int idx;
    d = 'x;
    for (int b = 0; b < 8; b++) begin
      idx = acc + 1 + CPB * (1 + b) + CPB / 2;
      if (idx < tx_q.size()) d[b] = tx_q[idx];
    end
    return d;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_t    = 0;
    m_gid  = 0;
    m_ptr  = 0;
    m_byte = '0;
  endtask

  // Each call runs one clock cycle. The task enters at a negedge, drives the inputs, checks the outputs, then advances the model at the posedge.
  task automatic cyc(input bit r, input logic [3:0] v, input logic [31:0] d);
    logic [3:0] exp_rdy;
    int w;
    rst       = r;
    req_valid = v;
    req_data  = d;
    #1;
    exp_rdy = '0;
    w = rr_pick(v);
    if (!m_busy && !r && w >= 0) exp_rdy[w] = 1'b1;
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("req_ready", req_ready, exp_rdy);
    tx_q.push_back(tx);
    if (busy) busy_cnt++;
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cycle_no);
      end
    @(posedge clk);
    if (r) model_reset();
    else if (m_busy) begin
      m_t++;
      if (m_t == FRAME) m_busy = 1'b0;
    end else if (w >= 0) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_gid  = w;
      m_ptr  = (w + 1) % NR;
      m_byte = d[8*w +: 8];
    end
    @(negedge clk);
    cycle_no++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 4'($urandom), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, $urandom);
  endtask

  task automatic clear_log();
    g_idx.delete();
    g_cyc.delete();
    busy_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5];
    logic [3:0] rv;
    logic [31:0] rd;
    exp_seq = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset(3);

    // One 0x55 byte from requester 0.
    clear_log();
    cyc(1'b0, 4'b0001, {$urandom_range(0, 255), 24'h000055} & 32'hFFFF_FF55 | 32'h55);
    idle(FRAME + 5);
    chk("s1_busy_len", busy_cnt, FRAME);
    chk("s1_ngrant", g_idx.size(), 1);
    if (g_idx.size() >= 1) begin
      chk("s1_gid", g_idx[0], 0);
      chk("s1_byte", decode(g_cyc[0]), 8'h55);
    end

    // All four requesters valid continuously.
    do_reset(1);
    clear_log();
    for (int i = 0; i < 4 * (FRAME + 1) + 6; i++) cyc(1'b0, 4'b1111, $urandom);
    idle(FRAME + 2);
    chk("s2_ngrant", g_idx.size(), 5);
    for (int i = 0; i < 5 && i < g_idx.size(); i++) chk("s2_seq", g_idx[i], exp_seq[i]);
    for (int i = 1; i < 5 && i < g_cyc.size(); i++) chk("s2_gap", g_cyc[i] - g_cyc[i-1], FRAME + 1);

    // After a grant to 2, only requesters 1 and 3 are valid.
    do_reset(1);
    clear_log();
    cyc(1'b0, 4'b0100, $urandom);
    for (int i = 0; i < 2 * (FRAME + 1) + 5; i++) cyc(1'b0, 4'b1010, $urandom);
    idle(FRAME + 2);
    chk("s3_ngrant", g_idx.size(), 3);
    if (g_idx.size() >= 3) begin
      chk("s3_first", g_idx[1], 3);
      chk("s3_second", g_idx[2], 1);
    end

    // Reset during data bit 3 of 0xA3.
    do_reset(1);
    clear_log();
    cyc(1'b0, 4'b0001, 32'h00C3_B1A3);
    idle(CPB + 3 * CPB + 2);
    cyc(1'b1, 4'b0000, $urandom);
    chk("s4_tx_after_rst", tx, 1'b1);
    chk("s4_busy_after_rst", busy, 1'b0);
    cyc(1'b0, 4'b1100, 32'h6E00_0000 | ($urandom & 32'h00FF_FFFF));
    idle(FRAME + 3);
    chk("s4_ngrant", g_idx.size(), 2);
    if (g_idx.size() >= 2) begin
      chk("s4_next_gid", g_idx[1], 2);
      chk("s4_next_byte", decode(g_cyc[1]), m_byte);
    end

    // Requester 2 changes its data just after the accept edge.
    do_reset(1);
    clear_log();
    cyc(1'b0, 4'b0100, 32'h000F_0000);
    for (int i = 0; i < FRAME + 3; i++) cyc(1'b0, 4'b0000, 32'h00F0_0000 | ($urandom & 32'hFF00_FFFF));
    chk("s5_ngrant", g_idx.size(), 1);
    if (g_idx.size() >= 1) chk("s5_byte", decode(g_cyc[0]), 8'h0F);

    // A one-cycle pulse while busy is ignored; a pulse in IDLE is accepted.
    do_reset(1);
    clear_log();
    cyc(1'b0, 4'b0001, $urandom);
    idle(10);
    cyc(1'b0, 4'b0010, $urandom);
    idle(FRAME);
    chk("s6_busy_pulse", g_idx.size(), 1);
    cyc(1'b0, 4'b0010, $urandom);
    chk("s6_idle_pulse_n", g_idx.size(), 2);
    if (g_idx.size() >= 2) chk("s6_idle_pulse_gid", g_idx[1], 1);
    idle(FRAME + 2);

    // Randomized phase: valid bits toggle sparsely and reset is applied occasionally.
    rv = '0;
    rd = $urandom;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 19) == 0) rv[b] = ~rv[b];
      if ($urandom_range(0, 3) == 0) rd = $urandom;
      cyc(($urandom_range(0, 399) == 0), rv, rd);
    end
    idle(FRAME + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the serial line (range 2..8).
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit time (minimum 2).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe; byte i is taken on the edge where req_valid[i] and req_ready[i] are both high.
REQ-008 tx  output  1  serial line; idle high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 grant_id  output  clog2(NUM_REQ)  index of the requester whose frame is on the line; holds its last value when idle.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-012 IDLE: tx=1 and busy=0; if any req_valid is high, the arbiter picks a winner w and drives req_ready[w]=1 combinationally in the same cycle; on that edge the block captures the byte, sets grant_id=w and enters START.
REQ-013 req_ready SHALL be all-zero in every state except IDLE, and SHALL never have more than one bit set.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA: 8 bits, LSB first, each bit held for exactly CLKS_PER_BIT cycles; 3-bit bit index; after bit 7 enter STOP.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then enter IDLE.
REQ-017 busy=1 in START, DATA and STOP.
REQ-018 Frame length is 10*CLKS_PER_BIT cycles. The minimum spacing between grants is 10*CLKS_PER_BIT+1 cycles (one IDLE cycle between frames).
REQ-019 tx SHALL be driven from a register with no combinational glitch path.
REQ-020 Arbitration is round-robin: after granting w, the search order for the next grant starts at w+1 mod NUM_REQ; after reset it starts at 0.
REQ-021 A requester that stays valid SHALL be granted within NUM_REQ frames.
REQ-022 The captured byte is immune to later changes in req_data or req_valid; deasserting req_valid mid-frame has no effect on that frame.
REQ-023 req_valid dropping in the cycle before the accept edge: no grant is made and the FSM stays in IDLE.
REQ-024 The bit-time counter counts from 0 to CLKS_PER_BIT-1 and wraps to 0 at each bit boundary, with no extra cycle.

Reset
REQ-025 While rst=1 on a rising edge: FSM=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, round-robin pointer=0, counters=0.
REQ-026 rst asserted mid-frame SHALL abort the frame. tx returns to 1 on the next edge, and the aborted byte is discarded without being retransmitted.
REQ-027 The first grant is possible in the first cycle with rst=0.

Structure
REQ-028 Shared package uart_pkg SHALL hold: the state enum (IDLE/START/DATA/STOP), UART_DATA_BITS=8, UART_STOP_BITS=1, and the idle line level constant.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, index), parameterised on NUM_REQ.
REQ-030 The baud counter, bit index and shift register SHALL live in uart_tx_sched.

Verification (CLKS_PER_BIT=4, NUM_REQ=4)
REQ-031 Requester 0 sends 0x55 once -> req_ready[0] high for 1 cycle. tx then shows: 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy is high for 40 cycles.
REQ-032 All four requesters valid continuously -> grant_id sequence 0,1,2,3,0. Grants are 41 cycles apart.
REQ-033 Just after a grant to 2, only requesters 1 and 3 are valid -> next grant is 3, followed by 1.
REQ-034 rst pulsed during DATA bit 3 of 0xA3 -> tx=1 and busy=0 on the next edge. The next grant goes to the lowest valid index, and 0xA3 is not resent.
REQ-035 Requester 2 changes req_data from 0x0F to 0xF0 one cycle after its accept edge -> 0x0F is transmitted.
REQ-036 req_valid[1] is a 1-cycle pulse arriving while busy -> no grant to 1 and req_ready[1] stays 0; a pulse during IDLE -> accepted in that same cycle.
